// File: rtl/ms_pipe_array_if.sv
// Fetch-to-sum stage bundle: operand/psum beat in, product/psum beat out, rdy/ack both sides.
// Latency: none, wiring only.
// Backpressure: carried on o_in_ack (upstream) and i_out_ack (downstream).
interface ms_pipe_array_if #(
    parameter int ROWS    = 4,
    parameter int DWD     = 8,
    parameter int PSUMDWD = 32,
    parameter int ASUMDWD = 2*DWD,
    parameter int PIPEW   = 8,
    parameter int DEPTH   = 2
);
    localparam int CW = $clog2(DEPTH+1);

    logic                    i_in_rdy;
    logic                    o_in_ack;
    logic [ROWS*DWD-1:0]     i_ipix;
    logic [ROWS*DWD-1:0]     i_wpix;
    logic [ROWS*PSUMDWD-1:0] i_psum;
    logic                    i_signed;
    logic                    i_psum_slice;
    logic [1:0]              i_psum_sel;
    logic [ROWS-1:0]         i_row_en;
    logic [PIPEW-1:0]        i_pipe;
    logic                    i_flush;
    logic                    o_out_rdy;
    logic                    i_out_ack;
    logic [ROWS*ASUMDWD-1:0] o_sum;
    logic [ROWS*PSUMDWD-1:0] o_psum;
    logic [PIPEW-1:0]        o_pipe;
    logic [CW-1:0]           o_count;

    modport master (
        output i_in_rdy, i_ipix, i_wpix, i_psum, i_signed, i_psum_slice, i_psum_sel,
               i_row_en, i_pipe, i_flush, i_out_ack,
        input  o_in_ack, o_out_rdy, o_sum, o_psum, o_pipe, o_count
    );

    modport slave (
        input  i_in_rdy, i_ipix, i_wpix, i_psum, i_signed, i_psum_slice, i_psum_sel,
               i_row_en, i_pipe, i_flush, i_out_ack,
        output o_in_ack, o_out_rdy, o_sum, o_psum, o_pipe, o_count
    );
endinterface

// File: rtl/ms_pipe_array.sv
// PE multiply stage: per-row signed/unsigned multiply plus psum slicing, DEPTH-deep elastic pipe.
// Latency: DEPTH cycles from input accept to o_out_rdy; one beat per cycle under continuous ack.
// Backpressure: a stalled output holds its data; stalls ripple back until o_in_ack drops when full.
module ms_pipe_array #(
    parameter int ROWS    = 4,
    parameter int DWD     = 8,
    parameter int PSUMDWD = 32,
    parameter int ASUMDWD = 2*DWD,
    parameter int PIPEW   = 8,
    parameter int DEPTH   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ms_pipe_array_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = ROWS*ASUMDWD;
    localparam int PW = ROWS*PSUMDWD;

    logic [DEPTH-1:0] v_q, v_d, load;
    logic [SW-1:0]    sum_q  [DEPTH];
    logic [SW-1:0]    sum_d  [DEPTH];
    logic [PW-1:0]    psum_q [DEPTH];
    logic [PW-1:0]    psum_d [DEPTH];
    logic [PIPEW-1:0] pipe_q [DEPTH];
    logic [PIPEW-1:0] pipe_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    s0_sum;
    logic [PW-1:0]    s0_psum;
    logic             in_xfer, out_xfer;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DWD-1:0]     a, b;
        logic [2*DWD-1:0]   prod_s, prod_u;
        logic [ASUMDWD-1:0] ext_s, ext_u;
        logic [PSUMDWD-1:0] psum_in, psum_sh;
        int                 shamt;

        assign a       = bus.i_ipix[r*DWD +: DWD];
        assign b       = bus.i_wpix[r*DWD +: DWD];
        assign prod_s  = $signed({{DWD{a[DWD-1]}}, a}) * $signed({{DWD{b[DWD-1]}}, b});
        assign prod_u  = {{DWD{1'b0}}, a} * {{DWD{1'b0}}, b};
        assign ext_s   = ASUMDWD'($signed(prod_s));
        assign ext_u   = ASUMDWD'(prod_u);
        assign psum_in = bus.i_psum[r*PSUMDWD +: PSUMDWD];
        assign shamt   = int'(bus.i_psum_sel) * DWD;
        // Shifting by the full width or more must give zero, not a wrapped amount.
        assign psum_sh = (shamt >= PSUMDWD) ? '0 : (psum_in >> shamt);

        assign s0_sum[r*ASUMDWD +: ASUMDWD]  = !bus.i_row_en[r] ? '0 :
                                               (bus.i_signed ? ext_s : ext_u);
        assign s0_psum[r*PSUMDWD +: PSUMDWD] = !bus.i_row_en[r] ? '0 :
                                               (bus.i_psum_slice ? psum_sh : psum_in);
    end

    // Stage k may load when it or any stage after it has a hole, or the output is taken.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            load[k] = bus.i_out_ack;
            for (int j = k; j < DEPTH; j++) begin
                if (!v_q[j]) load[k] = 1'b1;
            end
        end
    end

    assign bus.o_in_ack  = load[0] && !bus.i_flush;
    assign in_xfer       = bus.i_in_rdy && load[0] && !bus.i_flush;
    assign out_xfer      = v_q[DEPTH-1] && bus.i_out_ack;

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            sum_d[k]  = sum_q[k];
            psum_d[k] = psum_q[k];
            pipe_d[k] = pipe_q[k];
        end
        if (load[0]) begin
            v_d[0]    = in_xfer;
            sum_d[0]  = s0_sum;
            psum_d[0] = s0_psum;
            pipe_d[0] = bus.i_pipe;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (load[k]) begin
                v_d[k]    = v_q[k-1];
                sum_d[k]  = sum_q[k-1];
                psum_d[k] = psum_q[k-1];
                pipe_d[k] = pipe_q[k-1];
            end
        end
        count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        if (bus.i_flush) begin
            v_d     = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sum_q[k]  <= '0;
                psum_q[k] <= '0;
                pipe_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) begin
                sum_q[k]  <= sum_d[k];
                psum_q[k] <= psum_d[k];
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign bus.o_out_rdy = v_q[DEPTH-1];
    assign bus.o_sum     = sum_q[DEPTH-1];
    assign bus.o_psum    = psum_q[DEPTH-1];
    assign bus.o_pipe    = pipe_q[DEPTH-1];
    assign bus.o_count   = count_q;
endmodule
